// File: rtl/enc_rem_check_if.sv
// Handshake bundle between the BCH encoder and the remainder checker.
interface enc_rem_check_if #(
    parameter int unsigned CW_W  = 75,
    parameter int unsigned PAR_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [CW_W-1:0]  in_cw;
    logic             out_valid;
    logic             out_ready;
    logic [PAR_W-1:0] out_rem;
    logic             out_err;

    // Producer/consumer side (encoder feeding words, sink taking results)
    modport master (
        output in_valid, in_cw, out_ready,
        input  in_ready, out_valid, out_rem, out_err
    );

    // Checker side
    modport slave (
        input  in_valid, in_cw, out_ready,
        output in_ready, out_valid, out_rem, out_err
    );
endinterface

// File: rtl/enc_rem_check.sv
// Divides a captured codeword by g(x), BITS_PER_CYC bits per cycle, MSB first,
// and reports the remainder plus a nonzero flag through a valid/ready handshake.
module enc_rem_check #(
    parameter int unsigned     CW_W         = 75,
    parameter int unsigned     PAR_W        = 12,
    parameter logic [PAR_W:0]  GEN_POLY     = 13'h1539,
    parameter int unsigned     BITS_PER_CYC = 5
) (
    input logic           clk,
    input logic           rst_n,
    enc_rem_check_if.slave bus
);
    localparam int unsigned Beats = CW_W / BITS_PER_CYC;
    localparam int unsigned CntW  = $clog2(Beats + 1);
    localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [CW_W-1:0]  sh_q, sh_d;
    logic [PAR_W-1:0] rem_q, rem_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [PAR_W-1:0] out_rem_q, out_rem_d;
    logic             out_err_q, out_err_d;
    logic [PAR_W-1:0] rem_step;

    // Chain BITS_PER_CYC division steps; the top bit of rem decides the g(x) subtraction.
    always_comb begin
        rem_step = rem_q;
        for (int k = 0; k < int'(BITS_PER_CYC); k++) begin
            rem_step = {rem_step[PAR_W-2:0], sh_q[CW_W-1-k]}
                     ^ ({PAR_W{rem_step[PAR_W-1]}} & GEN_POLY[PAR_W-1:0]);
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_rem_d   = out_rem_q;
        out_err_d   = out_err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    sh_d    = bus.in_cw;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                sh_d  = sh_q << BITS_PER_CYC;
                rem_d = rem_step;
                if (cnt_q == LastBeat) begin
                    // Counter parks on the last beat rather than wrapping.
                    out_rem_d   = rem_step;
                    out_err_d   = |rem_step;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sh_q        <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_rem_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_rem_q   <= out_rem_d;
            out_err_q   <= out_err_d;
        end
    end

    // in_ready is decoded from state only, so it stays high through reset.
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.out_rem   = out_rem_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_enc_rem_check.sv
// Self-checking bench for enc_rem_check: table vectors, random words against a
// long-division reference, and hand-written backpressure/reset/streaming sequences.
module tb_enc_rem_check;
    localparam int unsigned CW_W  = 75;
    localparam int unsigned PAR_W = 12;

    typedef struct {
        string            name;
        logic [CW_W-1:0]  cw;
        logic [PAR_W-1:0] rem;
        logic             err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    enc_rem_check_if #(.CW_W(CW_W), .PAR_W(PAR_W)) bus ();

    enc_rem_check #(
        .CW_W(CW_W), .PAR_W(PAR_W), .GEN_POLY(13'h1539), .BITS_PER_CYC(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: polynomial long division over GF(2), highest term first.
    function automatic logic [PAR_W-1:0] ref_mod(input logic [CW_W-1:0] v);
        logic [CW_W-1:0] g;
        g = CW_W'(13'h1539);
        for (int i = CW_W - 1; i >= int'(PAR_W); i--) begin
            if (v[i]) v = v ^ (g << (i - PAR_W));
        end
        return v[PAR_W-1:0];
    endfunction

    // Systematic encoder: message in the high bits, parity = (msg * x^12) mod g.
    function automatic logic [CW_W-1:0] encode(input logic [CW_W-PAR_W-1:0] msg);
        return {msg, ref_mod({msg, {PAR_W{1'b0}}})};
    endfunction

    function automatic logic [CW_W-1:0] rand_cw();
        return CW_W'({$urandom, $urandom, $urandom});
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int t = 0;
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({name, " in_ready wait"}, 32'(bus.in_ready), 32'd1);
    endtask

    // Called at a negedge; sends one word with out_ready=1 and checks full timing.
    task automatic run_word(input string name, input logic [CW_W-1:0] cw,
                            input logic [PAR_W-1:0] exp_rem, input logic exp_err);
        int n;
        bus.out_ready = 1'b1;
        wait_ready(name);
        bus.in_valid = 1'b1;
        bus.in_cw    = cw;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 32'(n), 32'd16);
        check({name, " out_rem"}, 32'(bus.out_rem), 32'(exp_rem));
        check({name, " out_err"}, 32'(bus.out_err), 32'(exp_err));
        @(negedge clk);
        check({name, " ready@17"}, {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    endtask

    initial begin
        logic [CW_W-1:0] w;
        logic [CW_W-1:0] bw[6];
        logic [PAR_W-1:0] expq[$];
        int n, idx, got, last, cyc, pos;
        bit cap;

        bus.in_valid  = 1'b0;
        bus.in_cw     = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset state", {28'd0, bus.in_ready, bus.out_valid, bus.out_err, 1'b0},
              32'b1000);
        check("reset out_rem", 32'(bus.out_rem), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        vecs.push_back('{"zero",  '0,              12'h000, 1'b0});
        vecs.push_back('{"bit0",  CW_W'(1),        12'h001, 1'b1});
        vecs.push_back('{"bit12", CW_W'(1) << 12,  12'h539, 1'b1});
        vecs.push_back('{"bit13", CW_W'(1) << 13,  12'hA72, 1'b1});
        vecs.push_back('{"bit14", CW_W'(1) << 14,  12'h1DD, 1'b1});
        for (int k = 0; k < 9; k++) begin
            logic [CW_W-PAR_W-1:0] msg;
            unique case (k)
                0: msg = '1;
                1: msg = 63'h1;
                2: msg = 63'h5555_5555_5555_5555;
                3: msg = 63'h4000_0000_0000_0000;
                default: msg = 63'({$urandom, $urandom});
            endcase
            w   = encode(msg);
            vecs.push_back('{$sformatf("enc%0d", k), w, 12'h000, 1'b0});
            pos = $urandom_range(0, CW_W - 1);
            vecs.push_back('{$sformatf("enc%0d flip%0d", k, pos), w ^ (CW_W'(1) << pos),
                             ref_mod(CW_W'(1) << pos), 1'b1});
        end
        foreach (vecs[i]) run_word(vecs[i].name, vecs[i].cw, vecs[i].rem, vecs[i].err);

        // Random words against the reference
        for (int k = 0; k < 8; k++) begin
            w = rand_cw();
            run_word($sformatf("rand%0d", k), w, ref_mod(w), ref_mod(w) != '0);
        end

        // Backpressure: DONE held 20 cycles while in_valid toggles
        bus.out_ready = 1'b0;
        wait_ready("bp");
        bus.in_valid = 1'b1;
        bus.in_cw    = CW_W'(1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp latency", 32'(n), 32'd16);
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = (c % 2 == 0);
            bus.in_cw    = rand_cw();
            @(negedge clk);
            check($sformatf("bp hold %0d", c),
                  {17'd0, bus.out_valid, bus.in_ready, bus.out_err, bus.out_rem},
                  {17'd0, 1'b1, 1'b0, 1'b1, 12'h001});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp release", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
        run_word("after bp", CW_W'(1) << 13, 12'hA72, 1'b1);

        // Asynchronous reset during beat 7; out_rem holds A72 beforehand
        wait_ready("rst");
        bus.in_valid = 1'b1;
        bus.in_cw    = CW_W'(1) << 12;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset", {16'd0, bus.out_valid, bus.out_err, bus.in_ready, 1'b0, bus.out_rem},
              {16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_word("post reset", CW_W'(1) << 12, 12'h539, 1'b1);

        // Back-to-back stream, in_valid held high
        foreach (bw[i]) bw[i] = rand_cw();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_cw     = bw[0];
        idx  = 0;
        got  = 0;
        last = -1;
        cyc  = 0;
        while (got < 6 && cyc < 300) begin
            cap = 1'b0;
            if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b2b extra result: got %0h expected none", bus.out_rem);
                end else begin
                    check($sformatf("b2b rem %0d", got), 32'(bus.out_rem), 32'(expq.pop_front()));
                end
                if (last >= 0) check("b2b spacing", 32'(cyc - last), 32'd17);
                last = cyc;
                got++;
            end
            if (bus.in_ready && bus.in_valid) begin
                expq.push_back(ref_mod(bus.in_cw));
                idx++;
                cap = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (cap) begin
                if (idx < 6) bus.in_cw = bw[idx];
                else bus.in_valid = 1'b0;
            end
        end
        check("b2b count", 32'(got), 32'd6);
        check("b2b leftover", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
